// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared state encoding and BCD constants for the divider
//                result-to-BCD conversion stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] ADJ   = 2'b01;
    localparam logic [1:0] SHIFT = 2'b10;
    localparam logic [1:0] FIN   = 2'b11;

    localparam logic [3:0] BCD_ERR_DIGIT = 4'hE;
    localparam logic [3:0] ADD3_THRESH   = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_ADJ   = ADJ,
        ST_SHIFT = SHIFT,
        ST_FIN   = FIN
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dd_lane.sv
`default_nettype none
// ============================================================================
//  Module      : dd_lane
//  Description : One double-dabble lane: {BCD accumulator, binary} register
//                with load, add-3 adjust and shift-left operations.
//  Revision    : 1.0 - initial release
// ============================================================================
module dd_lane
    import div_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 2
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  adj,
    input  logic                  shift,
    input  logic [WIDTH-1:0]      operand,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int SR_W = 4*DIGITS + WIDTH;

    logic [SR_W-1:0]     r_sr;
    logic [4*DIGITS-1:0] w_adj_bcd;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] w_dig;
            assign w_dig = r_sr[WIDTH + 4*gi +: 4];
            // Digit never exceeds 9, so the 4-bit add cannot carry out.
            assign w_adj_bcd[4*gi +: 4] = (w_dig >= ADD3_THRESH) ? (w_dig + 4'd3) : w_dig;
        end
    endgenerate

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_sr <= '0;
        end else if (load) begin
            r_sr <= {{(4*DIGITS){1'b0}}, operand};
        end else if (adj) begin
            r_sr <= {w_adj_bcd, r_sr[WIDTH-1:0]};
        end else if (shift) begin
            r_sr <= {r_sr[SR_W-2:0], 1'b0};
        end
    end

    assign bcd = r_sr[SR_W-1 -: 4*DIGITS];

endmodule
`default_nettype wire

// File: rtl/div_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : div_bcd_converter
//  Description : Captures divider quotient/remainder on Done and converts both
//                to packed BCD by serial double-dabble for the display.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_bcd_converter
    import div_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 2
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                Done,
    input  logic                Err,
    input  logic [WIDTH-1:0]    Q,
    input  logic [WIDTH-1:0]    R,
    output logic                Busy,
    output logic                Valid,
    output logic                Err_out,
    output logic [4*DIGITS-1:0] Q_bcd,
    output logic [4*DIGITS-1:0] R_bcd
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    generate
        if ((10 ** DIGITS) <= ((2 ** WIDTH) - 1)) begin : g_param_check
            $error("div_bcd_converter: DIGITS too small to hold a WIDTH-bit value");
        end
    endgenerate

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_load;
    logic                w_adj;
    logic                w_shift;
    logic                w_fin;
    logic                w_err_cap;
    logic [4*DIGITS-1:0] w_q_lane;
    logic [4*DIGITS-1:0] w_r_lane;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_adj       = 1'b0;
        w_shift     = 1'b0;
        w_fin       = 1'b0;
        w_err_cap   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Done) begin
                    if (Err) begin
                        w_err_cap = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_ADJ;
                    end
                end
            end
            ST_ADJ: begin
                w_adj       = 1'b1;
                w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                w_shift     = 1'b1;
                w_state_nxt = (r_cnt == CNT_W'(1)) ? ST_FIN : ST_ADJ;
            end
            ST_FIN: begin
                w_fin       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign Busy = (r_state != ST_IDLE);

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= CNT_W'(WIDTH);
        end else if (w_shift) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Result registers only move on capture, error or FIN, so a partial
    // conversion is never visible downstream.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            Valid   <= 1'b0;
            Err_out <= 1'b0;
            Q_bcd   <= '0;
            R_bcd   <= '0;
        end else if (w_load) begin
            Valid   <= 1'b0;
            Err_out <= 1'b0;
        end else if (w_err_cap) begin
            Valid   <= 1'b1;
            Err_out <= 1'b1;
            Q_bcd   <= {DIGITS{BCD_ERR_DIGIT}};
            R_bcd   <= '0;
        end else if (w_fin) begin
            Valid   <= 1'b1;
            Err_out <= 1'b0;
            Q_bcd   <= w_q_lane;
            R_bcd   <= w_r_lane;
        end
    end

    dd_lane #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_q_lane (
        .CLK     (CLK),
        .rst     (rst),
        .load    (w_load),
        .adj     (w_adj),
        .shift   (w_shift),
        .operand (Q),
        .bcd     (w_q_lane)
    );

    dd_lane #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_r_lane (
        .CLK     (CLK),
        .rst     (rst),
        .load    (w_load),
        .adj     (w_adj),
        .shift   (w_shift),
        .operand (R),
        .bcd     (w_r_lane)
    );

endmodule
`default_nettype wire

// File: tb/tb_div_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_bcd_converter
//  Description : Directed self-checking bench for div_bcd_converter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_bcd_converter;

    logic       CLK;
    logic       rst;
    logic       Done;
    logic       Err;
    logic [3:0] Q;
    logic [3:0] R;
    logic       Busy;
    logic       Valid;
    logic       Err_out;
    logic [7:0] Q_bcd;
    logic [7:0] R_bcd;

    int checks   = 0;
    int failures = 0;

    div_bcd_converter #(.WIDTH(4), .DIGITS(2)) dut (
        .CLK     (CLK),
        .rst     (rst),
        .Done    (Done),
        .Err     (Err),
        .Q       (Q),
        .R       (R),
        .Busy    (Busy),
        .Valid   (Valid),
        .Err_out (Err_out),
        .Q_bcd   (Q_bcd),
        .R_bcd   (R_bcd)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic busy, input logic valid,
                           input logic err, input logic [7:0] qb, input logic [7:0] rb);
        chk({tag, ".Busy"},    {31'd0, Busy},    {31'd0, busy});
        chk({tag, ".Valid"},   {31'd0, Valid},   {31'd0, valid});
        chk({tag, ".Err_out"}, {31'd0, Err_out}, {31'd0, err});
        chk({tag, ".Q_bcd"},   {24'd0, Q_bcd},   {24'd0, qb});
        chk({tag, ".R_bcd"},   {24'd0, R_bcd},   {24'd0, rb});
    endtask

    // Called at a falling edge; Done is sampled on the next rising edge (E0).
    // A second Done can be injected so that it is sampled at edge E<glitch_k>.
    task automatic run(input string tag, input logic [3:0] q, input logic [3:0] r,
                       input logic [7:0] eq, input logic [7:0] er,
                       input logic [7:0] pq, input logic [7:0] pr, input int glitch_k);
        Done = 1'b1; Err = 1'b0; Q = q; R = r;
        @(negedge CLK);
        chk({tag, ".E0.Busy"},  {31'd0, Busy},  32'd1);
        chk({tag, ".E0.Valid"}, {31'd0, Valid}, 32'd0);
        Q = 4'd0; R = 4'd0;
        for (int k = 1; k <= 9; k++) begin
            if (k == glitch_k) begin
                Done = 1'b1; Q = 4'd9; R = 4'd3;
            end else begin
                Done = 1'b0;
            end
            @(negedge CLK);
            if (k < 9) begin
                chk($sformatf("%s.E%0d", tag, k), {24'd0, Busy, Valid, Err_out, 5'd0, Q_bcd, R_bcd},
                    {24'd0, 1'b1, 1'b0, Err_out, 5'd0, pq, pr});
            end else begin
                chk_all({tag, ".E9"}, 1'b0, 1'b1, 1'b0, eq, er);
            end
        end
        Done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; Done = 1'b0; Err = 1'b0; Q = 4'd0; R = 4'd0;
        repeat (2) @(negedge CLK);
        chk_all("reset", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b0;
        @(negedge CLK);

        // 13/4
        run("q3r1", 4'd3, 4'd1, 8'h03, 8'h01, 8'h00, 8'h00, 0);
        repeat (2) @(negedge CLK);
        chk_all("hold", 1'b0, 1'b1, 1'b0, 8'h03, 8'h01);

        // 15/1 exercises the add-3 on digit >= 5
        run("q15r0", 4'd15, 4'd0, 8'h15, 8'h00, 8'h03, 8'h01, 0);

        // Err without Done is ignored
        Err = 1'b1;
        @(negedge CLK);
        Err = 1'b0;
        chk_all("err_nodone", 1'b0, 1'b1, 1'b0, 8'h15, 8'h00);

        // Divide by zero: single-cycle error path
        Done = 1'b1; Err = 1'b1; Q = 4'd5; R = 4'd5;
        @(negedge CLK);
        Done = 1'b0; Err = 1'b0;
        chk_all("div0", 1'b0, 1'b1, 1'b1, 8'hEE, 8'h00);
        @(negedge CLK);
        chk_all("div0_hold", 1'b0, 1'b1, 1'b1, 8'hEE, 8'h00);

        // Done while busy is ignored
        run("q12_glitch", 4'd12, 4'd1, 8'h12, 8'h01, 8'hEE, 8'h00, 3);

        // Reset mid-conversion
        Done = 1'b1; Q = 4'd13; R = 4'd3;
        @(negedge CLK);
        Done = 1'b0;
        repeat (4) @(negedge CLK);
        rst = 1'b1;
        #1;
        chk_all("rst_mid", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge CLK);
        rst = 1'b0;
        @(negedge CLK);
        chk_all("rst_after", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        run("q7r2", 4'd7, 4'd2, 8'h07, 8'h02, 8'h00, 8'h00, 0);

        // Back-to-back: second Done on first IDLE cycle after Valid
        run("q11r2", 4'd11, 4'd2, 8'h11, 8'h02, 8'h07, 8'h02, 0);
        run("b2b", 4'd4, 4'd1, 8'h04, 8'h01, 8'h11, 8'h02, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
